multicycle_hold_ctrl: RTL and testbench

//   Parametrised multi-cycle instruction hold controller for the execute stage.
//   It generalises the single-cycle SWP hold to N-cycle holds in two modes.

---
 rtl/multicycle_hold_ctrl.sv | 127 ++++++++++++
 tb/tb_multicycle_hold_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_hold_ctrl.sv
// Multi-cycle instruction hold controller for the execute stage.
// COUNT mode holds for an explicit number of extra cycles (SWP, MUL/MLA).
// LIST mode holds for one transfer per set bit of a register list (LDM/STM)
// and presents the register index of each transfer, lowest index first.
module multicycle_hold_ctrl #(
  parameter int CNT_W  = 5,
  parameter int LIST_W = 16,
  localparam int IDX_W = $clog2(LIST_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [LIST_W-1:0] i_list,
  output logic              o_hold,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_step,
  output logic              o_last,
  output logic [IDX_W-1:0]  o_reg_idx,
  output logic              o_reg_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic                hold_q;
  logic                last_q;
  logic [CNT_W-1:0]    step_q;
  logic [CNT_W-1:0]    k_q;
  logic [LIST_W-1:0]   mask_q;
  logic                mode_q;

  logic [CNT_W-1:0]    pop;
  logic [CNT_W-1:0]    k_in;
  logic [LIST_W-1:0]   list_rest;
  logic [LIST_W-1:0]   cur_mask;
  logic [IDX_W-1:0]    idx;
  logic                found;

  // Number of set bits in the incoming register list
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LIST_W; i++) begin
      pop = pop + CNT_W'(i_list[i]);
    end
  end

  // Extra hold cycles for the instruction being offered; an empty list is one transfer
  always_comb begin
    if (i_mode) begin
      k_in = (pop == '0) ? '0 : pop - CNT_W'(1);
    end else begin
      k_in = i_count;
    end
    list_rest = i_list & (i_list - LIST_W'(1));
  end

  // Lowest set bit of the active mask selects the current transfer register
  always_comb begin
    cur_mask = (state == IDLE) ? i_list : mask_q;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < LIST_W; i++) begin
      if (!found && cur_mask[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // Sequence FSM: accept in IDLE, step through RUN, abort on reset/flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= IDLE;
      hold_q <= 1'b0;
      last_q <= 1'b0;
      step_q <= '0;
      k_q    <= '0;
      mask_q <= '0;
      mode_q <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (i_start && (k_in != '0)) begin
            state  <= RUN;
            hold_q <= 1'b1;
            step_q <= CNT_W'(1);
            last_q <= (k_in == CNT_W'(1));
            k_q    <= k_in;
            mode_q <= i_mode;
            mask_q <= i_mode ? list_rest : '0;
          end
        end
        RUN: begin
          if (last_q) begin
            state  <= IDLE;
            hold_q <= 1'b0;
            last_q <= 1'b0;
            step_q <= '0;
            k_q    <= '0;
            mask_q <= '0;
            mode_q <= 1'b0;
          end else begin
            step_q <= step_q + CNT_W'(1);
            last_q <= ((step_q + CNT_W'(1)) == k_q);
            mask_q <= mask_q & (mask_q - LIST_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_hold      = hold_q;
  assign o_busy      = hold_q;
  assign o_step      = step_q;
  assign o_last      = last_q;
  assign o_reg_idx   = idx;
  assign o_reg_valid = (|cur_mask) && !((state == RUN) && !mode_q);

endmodule

// File: tb/tb_multicycle_hold_ctrl.sv
// Self-checking bench for multicycle_hold_ctrl: queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized stimulus.
module tb_multicycle_hold_ctrl;

  localparam int CNT_W  = 5;
  localparam int LIST_W = 16;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              flush = 1'b0;
  logic              i_start = 1'b0;
  logic              i_mode = 1'b0;
  logic [CNT_W-1:0]  i_count = '0;
  logic [LIST_W-1:0] i_list = '0;
  logic              o_hold;
  logic              o_busy;
  logic [CNT_W-1:0]  o_step;
  logic              o_last;
  logic [IDX_W-1:0]  o_reg_idx;
  logic              o_reg_valid;

  multicycle_hold_ctrl #(.CNT_W(CNT_W), .LIST_W(LIST_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .i_start(i_start), .i_mode(i_mode), .i_count(i_count), .i_list(i_list),
    .o_hold(o_hold), .o_busy(o_busy), .o_step(o_step), .o_last(o_last),
    .o_reg_idx(o_reg_idx), .o_reg_valid(o_reg_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [LIST_W-1:0] v);
    int c = 0;
    for (int i = 0; i < LIST_W; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int lowest(input logic [LIST_W-1:0] v);
    for (int i = 0; i < LIST_W; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: a running flag, step/length counters and a queue of
  // register indices still to be transferred.
  bit m_run = 1'b0;
  int m_step = 0;
  int m_k = 0;
  bit m_list = 1'b0;
  int m_q[$];
  int m_newk;

  always @(posedge clk) begin
    if (rst || flush) begin
      m_run = 1'b0; m_step = 0; m_k = 0; m_q.delete();
    end else if (en) begin
      if (!m_run) begin
        if (i_start) begin
          if (i_mode) m_newk = (popc(i_list) == 0) ? 0 : popc(i_list) - 1;
          else        m_newk = int'(i_count);
          if (m_newk > 0) begin
            m_run = 1'b1; m_step = 1; m_k = m_newk; m_list = i_mode;
            m_q.delete();
            if (i_mode) begin
              for (int i = 0; i < LIST_W; i++) if (i_list[i]) m_q.push_back(i);
              void'(m_q.pop_front());
            end
          end
        end
      end else if (m_step == m_k) begin
        m_run = 1'b0; m_step = 0; m_q.delete();
      end else begin
        m_step++;
        if (m_list && m_q.size() > 0) void'(m_q.pop_front());
      end
    end
  end

  // Per-cycle comparison of every output against the model
  int e_idx;
  int e_valid;
  int lb;
  always @(posedge clk) begin
    #1;
    if (!m_run) begin
      lb = lowest(i_list);
      e_valid = (lb >= 0) ? 1 : 0;
      e_idx = (lb >= 0) ? lb : 0;
    end else if (m_list && m_q.size() > 0) begin
      e_valid = 1; e_idx = m_q[0];
    end else begin
      e_valid = 0; e_idx = 0;
    end
    chk("model_hold", int'(o_hold), int'(m_run));
    chk("model_busy", int'(o_busy), int'(m_run));
    chk("model_step", int'(o_step), m_step);
    chk("model_last", int'(o_last), (m_run && m_step == m_k) ? 1 : 0);
    chk("model_idx", int'(o_reg_idx), e_idx);
    chk("model_valid", int'(o_reg_valid), e_valid);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int cnt;
  int maxstep;

  initial begin
    rst = 1'b1; en = 1'b1;
    tick(); tick();
    chk("rst_hold", int'(o_hold), 0);
    chk("rst_step", int'(o_step), 0);
    chk("rst_last", int'(o_last), 0);
    rst = 1'b0;

    // SWP: one extra cycle
    i_mode = 1'b0; i_count = 5'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("swp_hold", int'(o_hold), 1);
    chk("swp_step", int'(o_step), 1);
    chk("swp_last", int'(o_last), 1);
    tick();
    chk("swp_done", int'(o_hold), 0);

    // LDM with list 8421
    i_mode = 1'b1; i_list = 16'h8421; i_start = 1'b1;
    #1;
    chk("ldm_idx0", int'(o_reg_idx), 0);
    chk("ldm_val0", int'(o_reg_valid), 1);
    tick();
    i_start = 1'b0;
    chk("ldm_s1", int'(o_step), 1);
    chk("ldm_idx1", int'(o_reg_idx), 5);
    tick();
    chk("ldm_s2", int'(o_step), 2);
    chk("ldm_idx2", int'(o_reg_idx), 10);
    tick();
    chk("ldm_s3", int'(o_step), 3);
    chk("ldm_idx3", int'(o_reg_idx), 15);
    chk("ldm_last3", int'(o_last), 1);
    tick();
    chk("ldm_done", int'(o_hold), 0);

    // Stall at step 2 for two cycles
    i_mode = 1'b0; i_count = 5'd4; i_start = 1'b1;
    cnt = 0;
    tick(); i_start = 1'b0; if (o_hold) cnt++;
    tick(); if (o_hold) cnt++;
    en = 1'b0;
    tick(); if (o_hold) cnt++;
    tick(); if (o_hold) cnt++;
    chk("stall_step", int'(o_step), 2);
    en = 1'b1;
    tick(); if (o_hold) cnt++;
    tick(); if (o_hold) cnt++;
    chk("stall_last", int'(o_last), 1);
    tick(); if (o_hold) cnt++;
    chk("stall_cycles", cnt, 6);

    // Flush at step 7 of a full list, then a fresh accept
    i_mode = 1'b1; i_list = 16'hFFFF; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (6) tick();
    chk("flush_pre_step", int'(o_step), 7);
    chk("flush_pre_idx", int'(o_reg_idx), 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hold", int'(o_hold), 0);
    chk("flush_step", int'(o_step), 0);
    i_mode = 1'b0; i_count = 5'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("reacc_hold", int'(o_hold), 1);
    chk("reacc_last", int'(o_last), 0);
    tick(); tick();
    chk("reacc_done", int'(o_hold), 0);

    // Edges: empty list, zero count, maximum count with i_start held high
    i_mode = 1'b1; i_list = 16'h0000; i_start = 1'b1;
    tick();
    chk("empty_list", int'(o_hold), 0);
    i_mode = 1'b0; i_count = 5'd0;
    tick();
    chk("zero_count", int'(o_hold), 0);
    i_count = 5'd31;
    tick();
    cnt = 0; maxstep = 0;
    while (o_hold && cnt < 40) begin
      cnt++;
      if (int'(o_step) > maxstep) maxstep = int'(o_step);
      tick();
    end
    i_start = 1'b0;
    chk("max_cycles", cnt, 31);
    chk("max_step", maxstep, 31);
    tick();
    chk("max_idle", int'(o_hold), 0);

    // Reset in the middle of a run
    i_count = 5'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick();
    chk("mid_step3", int'(o_step), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_hold", int'(o_hold), 0);
    chk("mid_rst_step", int'(o_step), 0);
    chk("mid_rst_last", int'(o_last), 0);

    // Randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      flush   = ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 5) != 0);
      i_start = ($urandom_range(0, 2) == 0);
      i_mode  = $urandom_range(0, 1);
      i_count = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 31))
                                             : CNT_W'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: i_list = 16'h0000;
        1: i_list = LIST_W'($urandom);
        2: i_list = LIST_W'($urandom & $urandom & $urandom);
        default: i_list = LIST_W'($urandom) & 16'h00F0;
      endcase
      tick();
    end
    rst = 1'b0; flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
